// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-in/first-out buffer for decoupling producer
// and consumer logic within one clock domain.
//
// Parameters:
//   BUS_WIDTH  - data word width in bits
//   DEPTH_LOG2 - log2 of storage depth (depth = 2**DEPTH_LOG2 words)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   datain    - write data, sampled on an accepted write
//   wr        - write request (accepted when not full)
//   rd        - read request (accepted when not empty)
//   dataout   - registered read data, holds when no read is accepted
//   full      - occupancy == depth
//   empty_n   - occupancy != 0
//   overflow  - sticky: write attempted while full   (SYNC_FIFO_ERR_EN only)
//   underflow - sticky: read attempted while empty   (SYNC_FIFO_ERR_EN only)
//
// Build option: define SYNC_FIFO_ERR_EN to add the overflow/underflow flags.

module sync_fifo #(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] datain,
  input  logic                 wr,
  input  logic                 rd,
  output logic [BUS_WIDTH-1:0] dataout,
  output logic                 full,
`ifdef SYNC_FIFO_ERR_EN
  output logic                 empty_n,
  output logic                 overflow,
  output logic                 underflow
`else
  output logic                 empty_n
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  // Count value at which the buffer is full: MSB set, rest clear.
  localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [BUS_WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [BUS_WIDTH-1:0]  r_dataout;

  logic w_full;
  logic w_empty_n;
  logic w_wr_acc;
  logic w_rd_acc;

  // Flags decode the registered count only, so admission never depends on
  // same-cycle activity: no write into a full buffer even if a read is
  // accepted, no read-through of a word being written into an empty one.
  assign w_full    = (r_count == C_FULL);
  assign w_empty_n = (r_count != '0);
  assign w_wr_acc  = wr && !w_full;
  assign w_rd_acc  = rd && w_empty_n;

  assign full    = w_full;
  assign empty_n = w_empty_n;
  assign dataout = r_dataout;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_wr_acc) begin
      r_mem[r_wr_ptr] <= datain;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_dataout <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + DEPTH_LOG2'(1);
        r_dataout <= r_mem[r_rd_ptr];
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd && !w_empty_n) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (BUS_WIDTH=4, depth 4). A queue holds
// the words the bench expects to see; accepted writes push, accepted reads
// pop and set the expected dataout.

module tb_sync_fifo;

  localparam int unsigned W = 4;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] datain;
  logic         wr;
  logic         rd;
  logic [W-1:0] dataout;
  logic         full;
  logic         empty_n;
`ifdef SYNC_FIFO_ERR_EN
  logic         overflow;
  logic         underflow;
`endif

  sync_fifo #(.BUS_WIDTH(W), .DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .datain   (datain),
    .wr       (wr),
    .rd       (rd),
    .dataout  (dataout),
    .full     (full),
`ifdef SYNC_FIFO_ERR_EN
    .empty_n  (empty_n),
    .overflow (overflow),
    .underflow(underflow)
`else
    .empty_n  (empty_n)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] sb[$];
  int           m_count;
  logic [W-1:0] m_dout;
  logic         m_ovf;
  logic         m_unf;
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".full"},    {31'd0, full},    {31'd0, (m_count == DEPTH)});
    check({tag, ".empty_n"}, {31'd0, empty_n}, {31'd0, (m_count != 0)});
    check({tag, ".dataout"}, {28'd0, dataout}, {28'd0, m_dout});
`ifdef SYNC_FIFO_ERR_EN
    check({tag, ".overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
    check({tag, ".underflow"}, {31'd0, underflow}, {31'd0, m_unf});
`endif
  endtask

  // One clock with the given requests; model updated from pre-edge state.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [W-1:0] d);
    logic wa, ra;
    wr = w; rd = r; datain = d;
    wa = w && (m_count != DEPTH);
    ra = r && (m_count != 0);
    if (w && m_count == DEPTH) m_ovf = 1'b1;
    if (r && m_count == 0)     m_unf = 1'b1;
    @(posedge clk); #1;
    if (ra) m_dout = sb.pop_front();
    if (wa) sb.push_back(d);
    m_count = m_count + int'(wa) - int'(ra);
    wr = 1'b0; rd = 1'b0;
    check_all(tag);
  endtask

  // Reset asserted for one edge with wr and rd both high.
  task automatic do_reset(input string tag);
    rst_n = 1'b0; wr = 1'b1; rd = 1'b1; datain = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1; wr = 1'b0; rd = 1'b0;
    sb.delete();
    m_count = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; datain = '0;
    m_count = 0; m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset, then an idle cycle proves the wr during reset was not recorded.
    do_reset("reset");
    cycle("post_reset_idle", 1'b0, 1'b0, 4'h0);

    // Single word.
    cycle("single_wr", 1'b1, 1'b0, 4'b0110);
    cycle("single_idle", 1'b0, 1'b0, 4'h0);
    cycle("single_rd", 1'b0, 1'b1, 4'h0);
    cycle("single_hold", 1'b0, 1'b0, 4'h0);

    // Fill to full, overflow attempt, drain.
    for (int i = 1; i <= 4; i++) cycle("fill_wr", 1'b1, 1'b0, W'(i));
    cycle("overflow_wr", 1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 4; i++) cycle("drain_rd", 1'b0, 1'b1, 4'h0);

    // Underflow: read on empty, flag sticky.
    cycle("underflow_rd", 1'b0, 1'b1, 4'h0);
    cycle("underflow_hold", 1'b0, 1'b0, 4'h0);

    // Simultaneous rd&wr with 2 stored words, across pointer wrap.
    cycle("pre_wr", 1'b1, 1'b0, 4'd2);
    cycle("pre_wr", 1'b1, 1'b0, 4'd3);
    for (int i = 10; i <= 15; i++) cycle("simul_rdwr", 1'b1, 1'b1, W'(i));

    // Fill, then rd&wr while full: only the read is accepted.
    cycle("top_wr", 1'b1, 1'b0, 4'd7);
    cycle("top_wr", 1'b1, 1'b0, 4'd8);
    cycle("full_rdwr", 1'b1, 1'b1, 4'd9);
    for (int i = 0; i < 3; i++) cycle("drain3_rd", 1'b0, 1'b1, 4'h0);

    // rd&wr while empty: only the write is accepted.
    cycle("empty_rdwr", 1'b1, 1'b1, 4'hA);
    cycle("empty_rdwr_rd", 1'b0, 1'b1, 4'h0);

    // Mid-operation reset discards contents.
    for (int i = 1; i <= 3; i++) cycle("mid_wr", 1'b1, 1'b0, W'(i + 4));
    do_reset("mid_reset");
    cycle("after_reset_wr", 1'b1, 1'b0, 4'd9);
    cycle("after_reset_rd", 1'b0, 1'b1, 4'h0);

    if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
